// File: rtl/fp8_pkg.sv
// Shared FP8 E4M3 definitions (S-EEEE-MMM, bias 7) for the MAC datapath arithmetic blocks.
package fp8_pkg;
  localparam int FP8_EXP_W = 4;
  localparam int FP8_MAN_W = 3;
  localparam int FP8_BIAS  = 7;

  localparam logic [6:0] FP8_MAX_FINITE = 7'h7E;
  localparam logic [6:0] FP8_NAN        = 7'h7F;

  typedef struct packed {
    logic                 sign;
    logic [FP8_EXP_W-1:0] exp;
    logic [FP8_MAN_W-1:0] man;
  } fp8_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/fp8_mant_div_step.sv
// One restoring-division step: conditional subtract of the divisor, then shift the remainder left.
module fp8_mant_div_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic         q_bit,
  output logic [W-1:0] r_next
);
  logic [W-1:0] r_sub;

  always_comb begin
    q_bit  = (r >= d);
    r_sub  = q_bit ? (r - d) : r;
    r_next = {r_sub[W-2:0], 1'b0};
  end
endmodule

// File: rtl/fp8_divider_seq.sv
// Sequential FP8 E4M3 divider, one mantissa quotient bit per clock, truncating.
// Define FP8_DIV_NAN_EN to treat S-1111-111 as NaN and add the nan_flag output.
module fp8_divider_seq
  import fp8_pkg::*;
#(
  parameter int EXP_W = FP8_EXP_W,
  parameter int MAN_W = FP8_MAN_W,
  parameter int BIAS  = FP8_BIAS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic       div_by_zero,
  output logic       overflow,
  output logic       underflow
`ifdef FP8_DIV_NAN_EN
  ,
  output logic       nan_flag
`endif
);
  localparam int QW = MAN_W + 2;          // hidden bit + mantissa + one guard for the <1 case
  localparam int CW = $clog2(QW);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_TOP = EW'((1 << EXP_W) - 1);

  div_state_t state, state_nxt;
  fp8_t fa, fb;
  logic a_zero, b_zero, special, sign_in;
  logic sign;
  logic [EXP_W-1:0] ea, eb;
  logic [QW-1:0] r, d, q, r_next;
  logic [CW-1:0] cnt;
  logic q_bit, lead, ovf, unf;
  logic [MAN_W-1:0] man_pack;
  logic signed [EW-1:0] e_pack;

  assign fa      = a;
  assign fb      = b;
  assign sign_in = fa.sign ^ fb.sign;
  assign a_zero  = (fa.exp == '0);
  assign b_zero  = (fb.exp == '0);

`ifdef FP8_DIV_NAN_EN
  logic nan_case;
  assign nan_case = (fa.exp == '1 && fa.man == '1) || (fb.exp == '1 && fb.man == '1) ||
                    (a_zero && b_zero);
  assign special  = nan_case || a_zero || b_zero;
`else
  assign special  = a_zero || b_zero;
`endif

  fp8_mant_div_step #(.W(QW)) u_step (
    .r      (r),
    .d      (d),
    .q_bit  (q_bit),
    .r_next (r_next)
  );

  // Normalise: a leading quotient bit of 0 means the mantissa ratio was below 1.
  always_comb begin
    lead     = q[QW-1];
    man_pack = lead ? q[QW-2:1] : q[QW-3:0];
    e_pack   = {2'b00, ea} - {2'b00, eb} + EW'(BIAS) - {{(EW-1){1'b0}}, ~lead};
    ovf      = (e_pack > E_TOP) || (e_pack == E_TOP && man_pack == '1);
    unf      = e_pack[EW-1] || (e_pack == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = special ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt == CW'(QW-1)) state_nxt = ST_PACK;
      ST_PACK: state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign <= 1'b0; ea <= '0; eb <= '0;
      r <= '0; d <= '0; q <= '0; cnt <= '0;
      quotient <= '0; div_by_zero <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
`ifdef FP8_DIV_NAN_EN
      nan_flag <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          sign <= sign_in; ea <= fa.exp; eb <= fb.exp;
          r <= QW'({1'b1, fa.man}); d <= QW'({1'b1, fb.man});
          q <= '0; cnt <= '0;
          div_by_zero <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
`ifdef FP8_DIV_NAN_EN
          nan_flag <= 1'b0;
          if (nan_case) begin
            quotient <= {sign_in, FP8_NAN};
            nan_flag <= 1'b1;
          end else
`endif
          if (b_zero) begin
            quotient    <= {sign_in, FP8_MAX_FINITE};
            div_by_zero <= 1'b1;
          end else if (a_zero) begin
            quotient <= {sign_in, 7'h00};
          end
        end
        ST_DIV: begin
          r   <= r_next;
          q   <= {q[QW-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        ST_PACK: begin
          if (ovf) begin
            quotient <= {sign, FP8_MAX_FINITE};
            overflow <= 1'b1;
          end else if (unf) begin
            quotient  <= {sign, 7'h00};
            underflow <= 1'b1;
          end else begin
            quotient <= {sign, e_pack[EXP_W-1:0], man_pack};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp8_divider_seq.sv
// Directed self-checking bench for fp8_divider_seq: arithmetic, special operands, range, handshake, reset.
module tb_fp8_divider_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, quotient;
  logic       div_by_zero, overflow, underflow;
`ifdef FP8_DIV_NAN_EN
  logic       nan_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp8_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef FP8_DIV_NAN_EN
    ,
    .nan_flag    (nan_flag)
`endif
  );

  // Drive one operand pair, count edges from acceptance (inclusive) to out_valid, then
  // sample the result. Leaves the design in DONE so callers may apply back-pressure.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, output int lat,
                       output logic [7:0] oq, output logic [2:0] oflags);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    oq     = quotient;
    oflags = {div_by_zero, overflow, underflow};
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'h00 ||
        {div_by_zero, overflow, underflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%h flags=%b, want 1 0 00 000",
               in_ready, out_valid, quotient, {div_by_zero, overflow, underflow});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'h4E, 8'h40, lat, q, f);
    checks++;
    if (q !== 8'h46 || f !== 3'b000) begin
      errors++; $display("FAIL basic_7_2: q=%h flags=%b, want 46 000", q, f);
    end
    checks++;
    if (lat !== 7) begin
      errors++; $display("FAIL basic_latency: got %0d edges, want 7", lat);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handshake_return: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sequence();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'h3C, 8'h3C, lat, q, f);
    checks++;
    if (q !== 8'h38) begin errors++; $display("FAIL div_1p5_1p5: q=%h, want 38", q); end
    release_out();
    issue(8'h38, 8'h3C, lat, q, f);
    checks++;
    if (q !== 8'h32 || f !== 3'b000) begin
      errors++; $display("FAIL div_1_1p5_trunc: q=%h flags=%b, want 32 000", q, f);
    end
    release_out();
  endtask

  task automatic test_special();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'h00, 8'h46, lat, q, f);
    checks++;
    if (q !== 8'h00 || f !== 3'b000 || lat !== 1) begin
      errors++; $display("FAIL zero_dividend: q=%h flags=%b lat=%0d, want 00 000 1", q, f, lat);
    end
    release_out();
    issue(8'h46, 8'h00, lat, q, f);
    checks++;
    if (q !== 8'h7E || f !== 3'b100 || lat !== 1) begin
      errors++; $display("FAIL div_by_zero_pos: q=%h flags=%b lat=%0d, want 7e 100 1", q, f, lat);
    end
    release_out();
    issue(8'hC6, 8'h00, lat, q, f);
    checks++;
    if (q !== 8'hFE || f !== 3'b100) begin
      errors++; $display("FAIL div_by_zero_neg: q=%h flags=%b, want fe 100", q, f);
    end
    release_out();
  endtask

  task automatic test_sign();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'hCE, 8'h40, lat, q, f);
    checks++;
    if (q !== 8'hC6 || f !== 3'b000) begin
      errors++; $display("FAIL neg_7_2: q=%h flags=%b, want c6 000 (flags cleared)", q, f);
    end
    release_out();
    issue(8'h4C, 8'h3C, lat, q, f);
    checks++;
    if (q !== 8'h48) begin errors++; $display("FAIL div_6_1p5: q=%h, want 48", q); end
    release_out();
  endtask

  task automatic test_range();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'h77, 8'h08, lat, q, f);
    checks++;
    if (q !== 8'h7E || f !== 3'b010) begin
      errors++; $display("FAIL overflow: q=%h flags=%b, want 7e 010", q, f);
    end
    release_out();
    issue(8'h08, 8'h77, lat, q, f);
    checks++;
    if (q !== 8'h00 || f !== 3'b001) begin
      errors++; $display("FAIL underflow: q=%h flags=%b, want 00 001", q, f);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] q; logic [2:0] f;
    issue(8'h4E, 8'h40, lat, q, f);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || quotient !== 8'h46 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b q=%h in_ready=%b, want 1 46 0",
                 i, out_valid, quotient, in_ready);
      end
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] q; logic [2:0] f;
    @(negedge clk);
    in_valid = 1'b1; a = 8'h4E; b = 8'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'h00 ||
        {div_by_zero, overflow, underflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_div: in_ready=%b out_valid=%b q=%h, want 1 0 00",
               in_ready, out_valid, quotient);
    end
    @(negedge clk); rst = 1'b0;
    issue(8'h4E, 8'h40, lat, q, f);
    checks++;
    if (q !== 8'h46 || lat !== 7) begin
      errors++; $display("FAIL after_reset: q=%h lat=%0d, want 46 7", q, lat);
    end
    release_out();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_basic();
    test_sequence();
    test_special();
    test_sign();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp8_divider_seq.md
Name: fp8_divider_seq

Overview:
Sequential FP8 E4M3 divider (S-EEEE-MMM, bias 7), quotient = a / b.
- It is the inverse-operation companion to the combinational FP8 multiplier in the MAC datapath.
- Uses one restoring-division step per clock, with valid/ready handshakes on both sides.
- Rounding is truncation, so it matches the multiplier (6.0*3.5 yields 20.0).

Parameters:
EXP_W, 4, exponent width
MAN_W, 3, stored mantissa width
BIAS, 7, exponent bias

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
a  in  8  dividend, E4M3
b  in  8  divisor, E4M3
out_valid  out  1  quotient valid
out_ready  in  1  consumer accepts quotient
quotient  out  8  result, E4M3
div_by_zero  out  1  flag, valid with out_valid
overflow  out  1  flag, valid with out_valid
underflow  out  1  flag, valid with out_valid

Behaviour:
- Reset (async, active-high):
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, all flags=0.
  - Reset asserted mid-operation aborts it; the in-flight result is discarded.
- FSM states: IDLE, DIV, PACK, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid, operands are captured at the clock edge (edge 0).
  - sign = a[7]^b[7].
  - If exp(b)==0: go DONE with quotient={sign,7'h7E}, div_by_zero=1.
  - Else if exp(a)==0: go DONE with quotient={sign,7'h00}.
    - Exponent 0 is always treated as zero; subnormals flush to zero.
  - Otherwise go DIV with r={1,ma}, d={1,mb}, cnt=0.
- DIV (5 cycles, cnt 0..4), restoring step per cycle:
  - If r>=d: q bit=1, r=r-d.
  - Then r<<=1.
  - Quotient bits fill q[4] down to q[0]; r is 5 bits wide.
  - After cnt==4, go PACK.
- PACK (1 cycle):
  - e = ea - eb + BIAS - (q[4]?0:1), 6-bit signed; range -8..21.
  - Mantissa = q[4] ? q[3:1] : q[2:0] (truncation).
  - If e>15, or e==15 with mantissa==111: quotient={sign,7'h7E}, overflow=1.
    - The value is saturated to max finite 448.
  - If e<=0: quotient={sign,7'h00}, underflow=1.
  - Else quotient={sign,e[3:0],mantissa}.
  - Go DONE.
- DONE:
  - out_valid=1; quotient and flags are held stable until out_valid&out_ready.
  - On that handshake: go IDLE, out_valid=0 next cycle.
  - in_ready=0 in every state except IDLE; there is no same-cycle accept on output handshake.
- Latency from acceptance edge to first out_valid high:
  - Normal path: out_valid high after 7 edges (5 DIV + 1 PACK + 1 DONE entry).
  - Zero / divide-by-zero path: out_valid high after 1 edge.
- Flags are cleared on every new acceptance.

Optional Feature:
FP8_DIV_NAN_EN
- Defined:
  - Operands 0x7F/0xFF (S-1111-111) are NaN.
  - Any NaN operand, or 0/0, produces quotient={sign,7'h7F} via the 1-cycle path.
  - Output nan_flag (1 bit) goes high; no other flag is set.
- Undefined:
  - No nan_flag port.
  - 1111_111 operands are ordinary values (480).
  - 0/0 behaves as divide-by-zero.

Decomposition:
- Package fp8_pkg:
  - E4M3 field widths, BIAS=7.
  - FP8_MAX_FINITE=7'h7E, FP8_NAN=7'h7F.
  - fp8_t struct {sign, exp, man}.
  - Divider state enum.
- Sub-module fp8_mant_div_step:
  - Combinational single restoring step: r, d in; q bit and next r out.
  - Instantiated once and reused each DIV cycle.

Test Plan:
- 0x4E / 0x40 (7.0/2.0): quotient=0x46 (3.5), out_valid exactly 7 edges after acceptance, all flags 0.
- 0x3C then 0x38 / 0x3C (1.5/1.5, then 1.0/1.5): first quotient=0x38 (1.0); second quotient=0x32 (0.625, truncated from 0.667).
- 0xCE / 0x40 (-7.0/2.0): quotient=0xC6 (-3.5). Then 0x4C / 0x3C (6.0/1.5): quotient=0x48 (4.0).
- Special operands:
  - 0x00 / 0x46: quotient=0x00, 1-edge latency.
  - 0x46 / 0x00: quotient=0x7E, div_by_zero=1.
  - 0xC6 / 0x00: quotient=0xFE.
- Range limits:
  - 0x77 / 0x08 (240 / 2^-6): quotient=0x7E, overflow=1.
  - 0x08 / 0x77: quotient=0x00, underflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles in DONE: quotient stable and in_ready=0 throughout.
  - Assert rst during DIV cnt=2: outputs return to reset values immediately.
  - Next transaction 0x4E / 0x40 still gives 0x46.
